// File: rtl/dpram_rr_arbiter.sv
// Two-requester single-port storage with round-robin arbitration.
// After reset the array is cleared one entry per cycle (INIT), then
// grants are issued combinationally and the access happens on the
// same rising edge (RUN). Reads return data one cycle after the grant.
module dpram_rr_arbiter #(
  parameter int DW = 8,
  parameter int AW = 2
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          req0,
  input  logic          req1,
  input  logic          we0,
  input  logic          we1,
  input  logic [AW-1:0] addr0,
  input  logic [AW-1:0] addr1,
  input  logic [DW-1:0] wdata0,
  input  logic [DW-1:0] wdata1,
  output logic          gnt0,
  output logic          gnt1,
  output logic [DW-1:0] rdata0,
  output logic [DW-1:0] rdata1,
  output logic          rvalid0,
  output logic          rvalid1,
  output logic          ready
);

  localparam int DEPTH = 1 << AW;

  typedef enum logic {
    INIT,
    RUN
  } state_t;

  state_t        state;
  state_t        state_next;
  logic [AW-1:0] clr_cnt;
  logic          last_gnt;
  logic          run_ok;
  logic [DW-1:0] mem [DEPTH];

  // Grants are suppressed while reset is being sampled so no access
  // can slip through on the reset edge.
  assign run_ok = (state == RUN) && rst;
  assign ready  = (state == RUN);

  // Leave INIT once the clear counter has written the last entry.
  always_comb begin
    state_next = state;
    if (state == INIT && clr_cnt == AW'(DEPTH - 1)) begin
      state_next = RUN;
    end
  end

  // State register with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state <= INIT;
    end else begin
      state <= state_next;
    end
  end

  // Clear counter walks every address once during INIT.
  always_ff @(posedge clk) begin
    if (!rst) begin
      clr_cnt <= '0;
    end else if (state == INIT) begin
      clr_cnt <= clr_cnt + AW'(1);
    end
  end

  // Round-robin grant: on a tie the requester not granted last wins.
  always_comb begin
    gnt0 = 1'b0;
    gnt1 = 1'b0;
    if (run_ok) begin
      if (req0 && req1) begin
        if (last_gnt) begin
          gnt0 = 1'b1;
        end else begin
          gnt1 = 1'b1;
        end
      end else begin
        gnt0 = req0;
        gnt1 = req1;
      end
    end
  end

  // Remember who was granted; starts at 1 so requester 0 wins first tie.
  always_ff @(posedge clk) begin
    if (!rst) begin
      last_gnt <= 1'b1;
    end else if (gnt0) begin
      last_gnt <= 1'b0;
    end else if (gnt1) begin
      last_gnt <= 1'b1;
    end
  end

  // Storage write port: clearing during INIT, granted writes during RUN.
  always_ff @(posedge clk) begin
    if (rst) begin
      if (state == INIT) begin
        mem[clr_cnt] <= '0;
      end else if (gnt0 && we0) begin
        mem[addr0] <= wdata0;
      end else if (gnt1 && we1) begin
        mem[addr1] <= wdata1;
      end
    end
  end

  // Registered read data and one-cycle valid pulse per requester.
  always_ff @(posedge clk) begin
    if (!rst) begin
      rdata0  <= '0;
      rdata1  <= '0;
      rvalid0 <= 1'b0;
      rvalid1 <= 1'b0;
    end else begin
      rvalid0 <= gnt0 && !we0;
      rvalid1 <= gnt1 && !we1;
      if (gnt0 && !we0) begin
        rdata0 <= mem[addr0];
      end
      if (gnt1 && !we1) begin
        rdata1 <= mem[addr1];
      end
    end
  end

endmodule

// File: tb/tb_dpram_rr_arbiter.sv
// Directed testbench for dpram_rr_arbiter with hand-computed expectations.
module tb_dpram_rr_arbiter;

  localparam int DW = 8;
  localparam int AW = 2;

  logic          clk;
  logic          rst;
  logic          req0, req1, we0, we1;
  logic [AW-1:0] addr0, addr1;
  logic [DW-1:0] wdata0, wdata1;
  logic          gnt0, gnt1, rvalid0, rvalid1, ready;
  logic [DW-1:0] rdata0, rdata1;

  int testCount = 0;
  int failCount = 0;

  dpram_rr_arbiter #(.DW(DW), .AW(AW)) dut (
    .clk    (clk),
    .rst    (rst),
    .req0   (req0),
    .req1   (req1),
    .we0    (we0),
    .we1    (we1),
    .addr0  (addr0),
    .addr1  (addr1),
    .wdata0 (wdata0),
    .wdata1 (wdata1),
    .gnt0   (gnt0),
    .gnt1   (gnt1),
    .rdata0 (rdata0),
    .rdata1 (rdata1),
    .rvalid0(rvalid0),
    .rvalid1(rvalid1),
    .ready  (ready)
  );

  // Free-running clock, 10 time units per period.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Compare one observed value against its expectation.
  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    testCount++;
    if (observed !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, observed, expected);
    end
  endtask

  // Drive both requester interfaces in one go.
  task automatic applyStimulus(input logic r0, input logic w0, input logic [AW-1:0] a0,
                               input logic [DW-1:0] d0, input logic r1, input logic w1,
                               input logic [AW-1:0] a1, input logic [DW-1:0] d1);
    req0 = r0; we0 = w0; addr0 = a0; wdata0 = d0;
    req1 = r1; we1 = w1; addr1 = a1; wdata1 = d1;
  endtask

  // Advance one clock and settle just after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Check the combinational grants for the inputs currently driven.
  task automatic checkGrants(input string tag, input logic g0, input logic g1);
    #1;
    checkOutput({tag, ".gnt0"}, 32'(gnt0), 32'(g0));
    checkOutput({tag, ".gnt1"}, 32'(gnt1), 32'(g1));
  endtask

  initial begin
    rst = 1'b0;
    applyStimulus(1'b1, 1'b0, 2'd0, 8'h00, 1'b0, 1'b0, 2'd0, 8'h00);
    tick();
    tick();
    checkOutput("reset.ready", 32'(ready), 0);
    checkOutput("reset.rvalid0", 32'(rvalid0), 0);
    checkOutput("reset.rvalid1", 32'(rvalid1), 0);
    checkOutput("reset.rdata0", 32'(rdata0), 0);
    checkOutput("reset.rdata1", 32'(rdata1), 0);
    checkGrants("reset", 1'b0, 1'b0);

    // Release reset with both requesters reading; INIT ignores them.
    rst = 1'b1;
    applyStimulus(1'b1, 1'b0, 2'd0, 8'h00, 1'b1, 1'b0, 2'd1, 8'h00);
    for (int i = 0; i < 4; i++) begin
      checkGrants($sformatf("init%0d", i), 1'b0, 1'b0);
      checkOutput($sformatf("init%0d.ready", i), 32'(ready), 0);
      tick();
    end
    checkOutput("run.ready", 32'(ready), 1);
    checkGrants("tie1", 1'b1, 1'b0);
    tick();
    checkOutput("tie1.rvalid0", 32'(rvalid0), 1);
    checkOutput("tie1.rvalid1", 32'(rvalid1), 0);
    checkOutput("tie1.rdata0", 32'(rdata0), 0);
    checkGrants("tie2", 1'b0, 1'b1);
    tick();
    checkOutput("tie2.rvalid0", 32'(rvalid0), 0);
    checkOutput("tie2.rvalid1", 32'(rvalid1), 1);
    checkOutput("tie2.rdata1", 32'(rdata1), 0);
    applyStimulus(1'b1, 1'b0, 2'd2, 8'h00, 1'b1, 1'b0, 2'd3, 8'h00);
    checkGrants("tie3", 1'b1, 1'b0);
    tick();
    checkOutput("tie3.rvalid0", 32'(rvalid0), 1);
    checkOutput("tie3.rvalid1", 32'(rvalid1), 0);
    checkOutput("tie3.rdata0", 32'(rdata0), 0);
    checkGrants("tie4", 1'b0, 1'b1);
    tick();
    checkOutput("tie4.rvalid0", 32'(rvalid0), 0);
    checkOutput("tie4.rvalid1", 32'(rvalid1), 1);
    checkOutput("tie4.rdata1", 32'(rdata1), 0);

    // Write then read the same address from the other requester.
    applyStimulus(1'b1, 1'b1, 2'd2, 8'hA5, 1'b0, 1'b0, 2'd0, 8'h00);
    checkGrants("wr", 1'b1, 1'b0);
    tick();
    checkOutput("wr.rvalid0", 32'(rvalid0), 0);
    applyStimulus(1'b0, 1'b0, 2'd0, 8'h00, 1'b1, 1'b0, 2'd2, 8'h00);
    checkGrants("raw", 1'b0, 1'b1);
    tick();
    checkOutput("raw.rvalid1", 32'(rvalid1), 1);
    checkOutput("raw.rdata1", 32'(rdata1), 32'hA5);
    applyStimulus(1'b0, 1'b0, 2'd0, 8'h00, 1'b0, 1'b0, 2'd0, 8'h00);
    checkGrants("idle", 1'b0, 1'b0);
    tick();
    checkOutput("idle.rvalid1", 32'(rvalid1), 0);
    checkOutput("idle.rdata1hold", 32'(rdata1), 32'hA5);

    // Competing writes to addr1; requester 0 wins first, then 1.
    applyStimulus(1'b1, 1'b1, 2'd1, 8'h11, 1'b1, 1'b1, 2'd1, 8'h22);
    checkGrants("wtie1", 1'b1, 1'b0);
    tick();
    checkGrants("wtie2", 1'b0, 1'b1);
    tick();
    checkOutput("wtie.rvalid0", 32'(rvalid0), 0);
    checkOutput("wtie.rvalid1", 32'(rvalid1), 0);
    applyStimulus(1'b1, 1'b0, 2'd1, 8'h00, 1'b0, 1'b0, 2'd0, 8'h00);
    checkGrants("rd1", 1'b1, 1'b0);
    tick();
    checkOutput("rd1.rdata0", 32'(rdata0), 32'h22);
    checkOutput("rd1.rdata1", 32'(rdata1), 32'hA5);

    // Back-to-back reads by requester 0 while requester 1 is idle.
    applyStimulus(1'b1, 1'b0, 2'd2, 8'h00, 1'b0, 1'b0, 2'd0, 8'h00);
    for (int i = 0; i < 2; i++) begin
      checkGrants($sformatf("b2b%0d", i), 1'b1, 1'b0);
      tick();
      checkOutput($sformatf("b2b%0d.rvalid0", i), 32'(rvalid0), 1);
      checkOutput($sformatf("b2b%0d.rdata0", i), 32'(rdata0), 32'hA5);
    end

    // Reset lands on the edge of a granted read: no pulse, full re-clear.
    applyStimulus(1'b0, 1'b0, 2'd0, 8'h00, 1'b1, 1'b0, 2'd2, 8'h00);
    checkGrants("prerst", 1'b0, 1'b1);
    rst = 1'b0;
    checkGrants("rstedge", 1'b0, 1'b0);
    tick();
    checkOutput("rst2.rvalid1", 32'(rvalid1), 0);
    checkOutput("rst2.rvalid0", 32'(rvalid0), 0);
    checkOutput("rst2.ready", 32'(ready), 0);
    checkOutput("rst2.rdata1", 32'(rdata1), 0);
    rst = 1'b1;
    applyStimulus(1'b1, 1'b0, 2'd2, 8'h00, 1'b1, 1'b0, 2'd1, 8'h00);
    for (int i = 0; i < 4; i++) begin
      checkOutput($sformatf("reinit%0d.ready", i), 32'(ready), 0);
      checkGrants($sformatf("reinit%0d", i), 1'b0, 1'b0);
      tick();
    end
    checkOutput("rerun.ready", 32'(ready), 1);
    checkGrants("rerun1", 1'b1, 1'b0);
    tick();
    checkOutput("rerun1.rvalid0", 32'(rvalid0), 1);
    checkOutput("rerun1.rdata0", 32'(rdata0), 0);
    checkGrants("rerun2", 1'b0, 1'b1);
    tick();
    checkOutput("rerun2.rvalid1", 32'(rvalid1), 1);
    checkOutput("rerun2.rdata1", 32'(rdata1), 0);

    applyStimulus(1'b0, 1'b0, 2'd0, 8'h00, 1'b0, 1'b0, 2'd0, 8'h00);
    tick();
    $display("[TB] %0d tests run, %0d failed", testCount, failCount);
    $finish;
  end

  // Safety net so the run always terminates.
  initial begin
    #20000;
    $display("[TB] FAIL timeout: simulation did not complete");
    $fatal(1, "[TB] timeout");
  end

endmodule
